ras_ctrl: RTL and testbench

Return-address-stack controller that owns the stack pointer and top-of-stack register, and drives an external dual-port BRAM as the spill store. Port A is the write port; port B is the read port. The BRAM has 1-cycle registered read latency. Calls push a return address, returns pop it, and the stack wraps circularly on overflow. It sits between the fetch/branch unit and the stack BRAM instance.

---
 rtl/ras_ctrl_if.sv | 40 ++++
 rtl/ras_ctrl.sv | 135 +++++++++++++
 tb/tb_ras_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ras_ctrl_if.sv
// Bundle between the return-address-stack controller, the fetch/branch unit
// and the dual-port stack BRAM (port A write, port B registered read).
interface ras_ctrl_if #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
);
  localparam int ADDR = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 2);

  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             flush;
  logic             ready;
  logic [WIDTH-1:0] top;
  logic             top_valid;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             mem_we;
  logic [ADDR-1:0]  mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_re;
  logic [ADDR-1:0]  mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output push, push_data, pop, flush, mem_rdata,
    input  ready, top, top_valid, empty, full, count, overflow, underflow,
    input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );

  modport slave (
    input  push, push_data, pop, flush, mem_rdata,
    output ready, top, top_valid, empty, full, count, overflow, underflow,
    output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: TOS register plus a circular BRAM spill
// store; a refilling pop stalls one cycle while the BRAM read returns.
module ras_ctrl #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  ras_ctrl_if.slave bus
);
  localparam int ADDR = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 2);

  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH + 1);
  localparam logic [ADDR-1:0] ADDR_ONE = ADDR'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    count_r, count_s;
  logic [ADDR-1:0]  wptr_r, wptr_s;
  logic [WIDTH-1:0] tos_r, tos_s;
  logic             ovf_r, ovf_s;
  logic             udf_r, udf_s;
  logic             mem_we_s, mem_re_s;
  logic             req_push_s, req_pop_s;

  // Next-state, stack bookkeeping and memory enables
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    wptr_s     = wptr_r;
    tos_s      = tos_r;
    ovf_s      = 1'b0;
    udf_s      = 1'b0;
    mem_we_s   = 1'b0;
    mem_re_s   = 1'b0;
    req_push_s = bus.push && (state_r == ST_IDLE);
    req_pop_s  = bus.pop && (state_r == ST_IDLE);

    // Flush behaves exactly like reset and masks any in-flight refill data
    if (rst || bus.flush) begin
      state_s = ST_IDLE;
      count_s = CNT_ZERO;
      wptr_s  = ADDR'(0);
      tos_s   = WIDTH'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_push_s && req_pop_s) begin
            tos_s = bus.push_data;
            if (count_r == CNT_ZERO) begin
              count_s = CNT_ONE;
              udf_s   = 1'b1;
            end else begin
              count_s = count_r;
            end
          end else if (req_push_s) begin
            tos_s = bus.push_data;
            if (count_r != CNT_ZERO) begin
              mem_we_s = 1'b1;
              wptr_s   = wptr_r + ADDR_ONE;
            end else begin
              wptr_s = wptr_r;
            end
            // When full the spill write lands on the oldest slot
            if (count_r == CNT_FULL) begin
              ovf_s = 1'b1;
            end else begin
              count_s = count_r + CNT_ONE;
            end
          end else if (req_pop_s) begin
            if (count_r > CNT_ONE) begin
              mem_re_s = 1'b1;
              wptr_s   = wptr_r - ADDR_ONE;
              count_s  = count_r - CNT_ONE;
              state_s  = ST_REFILL;
            end else if (count_r == CNT_ONE) begin
              count_s = CNT_ZERO;
            end else begin
              udf_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_REFILL: begin
          tos_s   = bus.mem_rdata;
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, pointer, count, TOS and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
      wptr_r  <= ADDR'(0);
      tos_r   <= WIDTH'(0);
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      wptr_r  <= wptr_s;
      tos_r   <= tos_s;
      ovf_r   <= ovf_s;
      udf_r   <= udf_s;
    end
  end

  assign bus.ready     = (state_r == ST_IDLE);
  assign bus.top       = tos_r;
  assign bus.top_valid = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
  assign bus.empty     = (count_r == CNT_ZERO);
  assign bus.full      = (count_r == CNT_FULL);
  assign bus.count     = count_r;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = udf_r;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_waddr = wptr_r;
  assign bus.mem_wdata = tos_r;
  assign bus.mem_re    = mem_re_s;
  assign bus.mem_raddr = wptr_r - ADDR_ONE;
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed, table-driven bench for ras_ctrl with DEPTH=4 and a behavioural
// dual-port BRAM with one-cycle registered read.
module tb_ras_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  ras_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] bram [0:DEPTH-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack BRAM model: port A write, port B registered read
  always @(posedge clk) begin
    if (bus.mem_we) bram[bus.mem_waddr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= bram[bus.mem_raddr];
  end

  typedef struct {
    logic        rst, push, pop, flush;
    logic [31:0] data;
    logic        e_rdy, e_we, e_re;
    logic [1:0]  e_ad;
    logic [31:0] e_wd;
    logic [2:0]  e_cnt;
    logic        e_tv, chk_top;
    logic [31:0] e_top;
    logic        e_ovf, e_udf;
  } vec_t;

  vec_t vq[$];

  // ctl={rst,push,pop,flush}; pre={ready,mem_we,mem_re}; tc={top_valid,check top}; fl={overflow,underflow}
  function automatic vec_t v(input logic [3:0] ctl, input logic [31:0] d, input logic [2:0] pre,
                             input logic [1:0] ad, input logic [31:0] wd, input logic [2:0] cnt,
                             input logic [1:0] tc, input logic [31:0] top, input logic [1:0] fl);
    vec_t r;
    r.rst = ctl[3]; r.push = ctl[2]; r.pop = ctl[1]; r.flush = ctl[0];
    r.data = d;
    r.e_rdy = pre[2]; r.e_we = pre[1]; r.e_re = pre[0];
    r.e_ad = ad; r.e_wd = wd; r.e_cnt = cnt;
    r.e_tv = tc[1]; r.chk_top = tc[0]; r.e_top = top;
    r.e_ovf = fl[1]; r.e_udf = fl[0];
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    rst           = t.rst;
    bus.push      = t.push;
    bus.pop       = t.pop;
    bus.flush     = t.flush;
    bus.push_data = t.data;
    #1;
    chk("ready", idx, 32'(bus.ready), 32'(t.e_rdy));
    chk("mem_we", idx, 32'(bus.mem_we), 32'(t.e_we));
    chk("mem_re", idx, 32'(bus.mem_re), 32'(t.e_re));
    if (t.e_we) begin
      chk("mem_waddr", idx, 32'(bus.mem_waddr), 32'(t.e_ad));
      chk("mem_wdata", idx, bus.mem_wdata, t.e_wd);
    end
    if (t.e_re) chk("mem_raddr", idx, 32'(bus.mem_raddr), 32'(t.e_ad));
    @(posedge clk);
    #1;
    chk("count", idx, 32'(bus.count), 32'(t.e_cnt));
    chk("top_valid", idx, 32'(bus.top_valid), 32'(t.e_tv));
    chk("empty", idx, 32'(bus.empty), 32'(t.e_cnt == 3'd0));
    chk("full", idx, 32'(bus.full), 32'(t.e_cnt == 3'd5));
    chk("overflow", idx, 32'(bus.overflow), 32'(t.e_ovf));
    chk("underflow", idx, 32'(bus.underflow), 32'(t.e_udf));
    if (t.chk_top) chk("top", idx, bus.top, t.e_top);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got[$];
    logic [31:0] exp_pop[3];
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.push_data = 32'h0;

    // reset state
    vq.push_back(v(4'b0000, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b01, 32'h0,   2'b00));
    // basic LIFO, push ignored during refill
    vq.push_back(v(4'b0100, 32'h100,  3'b100, 2'd0, 32'h0,   3'd1, 2'b11, 32'h100, 2'b00));
    vq.push_back(v(4'b0100, 32'h200,  3'b110, 2'd0, 32'h100, 3'd2, 2'b11, 32'h200, 2'b00));
    vq.push_back(v(4'b0100, 32'h300,  3'b110, 2'd1, 32'h200, 3'd3, 2'b11, 32'h300, 2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd1, 32'h0,   3'd2, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0100, 32'hDEAD, 3'b000, 2'd0, 32'h0,   3'd2, 2'b11, 32'h200, 2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd0, 32'h0,   3'd1, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0000, 32'h0,    3'b000, 2'd0, 32'h0,   3'd1, 2'b11, 32'h100, 2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b00, 32'h0,   2'b00));
    // overflow: push 1..6, then pop 5
    vq.push_back(v(4'b0100, 32'd1,    3'b100, 2'd0, 32'h0,   3'd1, 2'b11, 32'd1,   2'b00));
    vq.push_back(v(4'b0100, 32'd2,    3'b110, 2'd0, 32'd1,   3'd2, 2'b11, 32'd2,   2'b00));
    vq.push_back(v(4'b0100, 32'd3,    3'b110, 2'd1, 32'd2,   3'd3, 2'b11, 32'd3,   2'b00));
    vq.push_back(v(4'b0100, 32'd4,    3'b110, 2'd2, 32'd3,   3'd4, 2'b11, 32'd4,   2'b00));
    vq.push_back(v(4'b0100, 32'd5,    3'b110, 2'd3, 32'd4,   3'd5, 2'b11, 32'd5,   2'b00));
    vq.push_back(v(4'b0100, 32'd6,    3'b110, 2'd0, 32'd5,   3'd5, 2'b11, 32'd6,   2'b10));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd0, 32'h0,   3'd4, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0000, 32'h0,    3'b000, 2'd0, 32'h0,   3'd4, 2'b11, 32'd5,   2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd3, 32'h0,   3'd3, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0000, 32'h0,    3'b000, 2'd0, 32'h0,   3'd3, 2'b11, 32'd4,   2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd2, 32'h0,   3'd2, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0000, 32'h0,    3'b000, 2'd0, 32'h0,   3'd2, 2'b11, 32'd3,   2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd1, 32'h0,   3'd1, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0000, 32'h0,    3'b000, 2'd0, 32'h0,   3'd1, 2'b11, 32'd2,   2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b00, 32'h0,   2'b00));
    // underflow
    vq.push_back(v(4'b0010, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b00, 32'h0,   2'b01));
    vq.push_back(v(4'b0000, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b00, 32'h0,   2'b00));
    // push+pop together
    vq.push_back(v(4'b0100, 32'hA,    3'b100, 2'd0, 32'h0,   3'd1, 2'b11, 32'hA,   2'b00));
    vq.push_back(v(4'b0100, 32'hB,    3'b110, 2'd1, 32'hA,   3'd2, 2'b11, 32'hB,   2'b00));
    vq.push_back(v(4'b0110, 32'hC,    3'b100, 2'd0, 32'h0,   3'd2, 2'b11, 32'hC,   2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd1, 32'h0,   3'd1, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0000, 32'h0,    3'b000, 2'd0, 32'h0,   3'd1, 2'b11, 32'hA,   2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0110, 32'hD,    3'b100, 2'd0, 32'h0,   3'd1, 2'b11, 32'hD,   2'b01));
    vq.push_back(v(4'b0010, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b00, 32'h0,   2'b00));
    // flush during refill, then flush beating a push
    vq.push_back(v(4'b0100, 32'h11,   3'b100, 2'd0, 32'h0,   3'd1, 2'b11, 32'h11,  2'b00));
    vq.push_back(v(4'b0100, 32'h22,   3'b110, 2'd1, 32'h11,  3'd2, 2'b11, 32'h22,  2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd1, 32'h0,   3'd1, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b0001, 32'h0,    3'b000, 2'd0, 32'h0,   3'd0, 2'b01, 32'h0,   2'b00));
    vq.push_back(v(4'b0000, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b01, 32'h0,   2'b00));
    vq.push_back(v(4'b0100, 32'h33,   3'b100, 2'd0, 32'h0,   3'd1, 2'b11, 32'h33,  2'b00));
    vq.push_back(v(4'b0101, 32'h44,   3'b100, 2'd0, 32'h0,   3'd0, 2'b01, 32'h0,   2'b00));
    // reset during refill
    vq.push_back(v(4'b0100, 32'h55,   3'b100, 2'd0, 32'h0,   3'd1, 2'b11, 32'h55,  2'b00));
    vq.push_back(v(4'b0100, 32'h66,   3'b110, 2'd0, 32'h55,  3'd2, 2'b11, 32'h66,  2'b00));
    vq.push_back(v(4'b0010, 32'h0,    3'b101, 2'd0, 32'h0,   3'd1, 2'b00, 32'h0,   2'b00));
    vq.push_back(v(4'b1010, 32'h0,    3'b000, 2'd0, 32'h0,   3'd0, 2'b01, 32'h0,   2'b00));
    vq.push_back(v(4'b0000, 32'h0,    3'b100, 2'd0, 32'h0,   3'd0, 2'b01, 32'h0,   2'b00));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // back-to-back pops: push 1..4, hold pop for 6 cycles
    for (int k = 1; k <= 4; k++) begin
      bus.push = 1'b1;
      bus.push_data = 32'(k);
      @(posedge clk);
      #1;
    end
    bus.push = 1'b0;
    chk("b2b count after pushes", 100, 32'(bus.count), 32'd4);
    chk("b2b top after pushes", 100, bus.top, 32'd4);
    bus.pop = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("b2b ready", 101 + c, 32'(bus.ready), 32'(c % 2 == 0));
      if (bus.ready && bus.top_valid) got.push_back(bus.top);
      @(posedge clk);
      #1;
    end
    bus.pop = 1'b0;
    exp_pop[0] = 32'd4;
    exp_pop[1] = 32'd3;
    exp_pop[2] = 32'd2;
    chk("b2b pops accepted", 110, 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) chk("b2b popped value", 111 + k, got[k], exp_pop[k]);
      else chk("b2b popped value missing", 111 + k, 32'hFFFF_FFFF, exp_pop[k]);
    end
    chk("b2b final count", 120, 32'(bus.count), 32'd1);
    chk("b2b final top_valid", 121, 32'(bus.top_valid), 32'd1);
    chk("b2b final top", 122, bus.top, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
